// File: rtl/fetch_stage.sv
// F-stage sequencer: owns the fetch PC, issues instruction-memory requests and
// loads the F/D pipeline register, buffering a returned word across a stall.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] NPC,
   input  logic        stall,
   output logic [31:0] F_PC,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic        F_busy,
   output logic [31:0] D_PC,
   output logic [31:0] D_Instr,
   output logic        state_dbg
);

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] f_pc_q, f_pc_d;
   logic [31:0] d_pc_q, d_pc_d;
   logic [31:0] d_instr_q, d_instr_d;
   logic [31:0] hold_buf_q, hold_buf_d;

   // Handshake: a request is live while imem_req=1 and completes in the cycle
   // imem_ready=1; imem_addr is held until then. imem_rdata is only looked at
   // in that completing cycle, and never while in HOLD or in reset.
   always_comb begin
      state_d    = state_q;
      f_pc_d     = f_pc_q;
      d_pc_d     = d_pc_q;
      d_instr_d  = d_instr_q;
      hold_buf_d = hold_buf_q;
      unique case (state_q)
         FETCH: begin
            if (imem_ready) begin
               if (stall) begin
                  hold_buf_d = imem_rdata;
                  state_d    = HOLD;
               end else begin
                  d_pc_d    = f_pc_q;
                  d_instr_d = imem_rdata;
                  f_pc_d    = NPC;
               end
            end
         end
         HOLD: begin
            if (!stall) begin
               d_pc_d    = f_pc_q;
               d_instr_d = hold_buf_q;
               f_pc_d    = NPC;
               state_d   = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FETCH;
         f_pc_q     <= RESET_PC;
         d_pc_q     <= 32'h0;
         d_instr_q  <= NOP_INSTR;
         hold_buf_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         f_pc_q     <= f_pc_d;
         d_pc_q     <= d_pc_d;
         d_instr_q  <= d_instr_d;
         hold_buf_q <= hold_buf_d;
      end
   end

   // Gating with reset drops the request the moment reset asserts.
   assign imem_req  = reset & (state_q == FETCH);
   assign imem_addr = f_pc_q;
   assign F_busy    = imem_req & ~imem_ready;
   assign F_PC      = f_pc_q;
   assign D_PC      = d_pc_q;
   assign D_Instr   = d_instr_q;
   assign state_dbg = (state_q == HOLD);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then a
// randomized run checked every cycle against a transaction-level model.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NPC;
  logic        stall;
  logic [31:0] F_PC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        F_busy;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic        state_dbg;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .NPC(NPC), .stall(stall), .F_PC(F_PC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .F_busy(F_busy), .D_PC(D_PC), .D_Instr(D_Instr),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: fetch PC, D register, and words returned by memory but not yet
  // accepted into D (at most one), each tagged with the PC it was fetched from.
  logic [31:0] m_fpc, m_dpc, m_dinstr;
  logic [63:0] exp_q[$];
  logic        m_rst_n;
  logic        cur_stall, cur_rdy;
  logic [31:0] cur_rdata, cur_npc;

  logic        o_req, o_busy;
  logic [31:0] o_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fpc    = RST_PC;
    m_dpc    = 32'h0;
    m_dinstr = 32'h0;
    exp_q.delete();
  endtask

  task automatic model_check();
    logic exp_req;
    exp_req = m_rst_n && (exp_q.size() == 0);
    chk("F_PC", F_PC, m_fpc);
    chk("imem_addr", imem_addr, m_fpc);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("F_busy", {31'b0, F_busy}, {31'b0, exp_req && !cur_rdy});
    chk("D_PC", D_PC, m_dpc);
    chk("D_Instr", D_Instr, m_dinstr);
    chk("state", {31'b0, state_dbg}, {31'b0, exp_q.size() != 0});
  endtask

  // An instruction reaches D on the first edge where a word for the current
  // PC is available (just returned, or returned earlier) and there is no stall.
  task automatic model_step();
    logic [63:0] e;
    if (exp_q.size() == 0 && cur_rdy) exp_q.push_back({m_fpc, cur_rdata});
    if (exp_q.size() != 0 && !cur_stall) begin
      e        = exp_q.pop_front();
      m_dpc    = e[63:32];
      m_dinstr = e[31:0];
      m_fpc    = cur_npc;
    end
  endtask

  // One clock: drive at the falling edge, check before the rising edge,
  // advance the model on the rising edge.
  task automatic cycle(input logic rst_v, input logic st, input logic rdy,
                       input logic [31:0] rdata, input logic redir, input logic [31:0] tgt);
    @(negedge clk);
    cur_stall  = st;
    cur_rdy    = rdy;
    cur_rdata  = rdata;
    cur_npc    = redir ? tgt : m_fpc + 32'd4;
    m_rst_n    = rst_v;
    reset      = rst_v;
    stall      = st;
    imem_ready = rdy;
    imem_rdata = rdata;
    NPC        = cur_npc;
    if (!rst_v) model_reset();
    #1;
    model_check();
    o_req  = imem_req;
    o_busy = F_busy;
    o_addr = imem_addr;
    @(posedge clk);
    if (rst_v) model_step();
    #2;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; NPC = 32'h0;
    m_rst_n = 1'b0; cur_stall = 1'b0; cur_rdy = 1'b0; cur_rdata = 32'h0; cur_npc = 32'h0;
    model_reset();

    // reset held three cycles, with memory ready (must be ignored)
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0);
      chk("lit_rst_busy", {31'b0, o_busy}, 32'd0);
      chk("lit_rst_req", {31'b0, o_req}, 32'd0);
      chk("lit_rst_fpc", F_PC, 32'h0000_3000);
      chk("lit_rst_dinstr", D_Instr, 32'h0);
    end

    // zero-wait stream
    cycle(1'b1, 1'b0, 1'b1, 32'h1000_0001, 1'b0, 32'h0);
    chk("lit_first_req", {31'b0, o_req}, 32'd1);
    chk("lit_s1_fpc", F_PC, 32'h0000_3004);
    chk("lit_s1_dpc", D_PC, 32'h0000_3000);
    chk("lit_s1_dinstr", D_Instr, 32'h1000_0001);
    cycle(1'b1, 1'b0, 1'b1, 32'h1000_0002, 1'b0, 32'h0);
    chk("lit_s2_fpc", F_PC, 32'h0000_3008);
    chk("lit_s2_dpc", D_PC, 32'h0000_3004);
    chk("lit_s2_dinstr", D_Instr, 32'h1000_0002);
    cycle(1'b1, 1'b0, 1'b1, 32'h1000_0003, 1'b0, 32'h0);
    chk("lit_s3_fpc", F_PC, 32'h0000_300C);
    chk("lit_s3_dinstr", D_Instr, 32'h1000_0003);

    // restart from reset, then two wait states at 0x3004
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("lit_rr_fpc", F_PC, 32'h0000_3000);
    cycle(1'b1, 1'b0, 1'b1, 32'hA000_0000, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0);
      chk("lit_wait_busy", {31'b0, o_busy}, 32'd1);
      chk("lit_wait_addr", o_addr, 32'h0000_3004);
      chk("lit_wait_dpc", D_PC, 32'h0000_3000);
    end
    cycle(1'b1, 1'b0, 1'b1, 32'hA000_0004, 1'b0, 32'h0);
    chk("lit_rdy_busy", {31'b0, o_busy}, 32'd0);
    chk("lit_rdy_dpc", D_PC, 32'h0000_3004);

    // stall capture at 0x3008
    cycle(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    chk("lit_cap_req", {31'b0, o_req}, 32'd1);
    chk("lit_cap_dpc", D_PC, 32'h0000_3004);
    chk("lit_cap_fpc", F_PC, 32'h0000_3008);
    chk("lit_cap_state", {31'b0, state_dbg}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'($urandom_range(1, 0)), $urandom(), 1'b0, 32'h0);
      chk("lit_hold_req", {31'b0, o_req}, 32'd0);
      chk("lit_hold_dpc", D_PC, 32'h0000_3004);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0BAD_0BAD, 1'b0, 32'h0);
    chk("lit_rel_req", {31'b0, o_req}, 32'd0);
    chk("lit_rel_dinstr", D_Instr, 32'hDEAD_BEEF);
    chk("lit_rel_dpc", D_PC, 32'h0000_3008);
    chk("lit_rel_fpc", F_PC, 32'h0000_300C);
    chk("lit_rel_state", {31'b0, state_dbg}, 32'd0);

    // branch at 0x300C, delay slot at 0x3010 with one wait state, target 0x3100
    cycle(1'b1, 1'b0, 1'b1, 32'h1000_0BEE, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3100);
    chk("lit_br_wait_dpc", D_PC, 32'h0000_300C);
    chk("lit_br_wait_fpc", F_PC, 32'h0000_3010);
    cycle(1'b1, 1'b0, 1'b1, 32'h2222_2222, 1'b1, 32'h0000_3100);
    chk("lit_br_fpc", F_PC, 32'h0000_3100);
    chk("lit_br_dpc", D_PC, 32'h0000_3010);
    chk("lit_br_dinstr", D_Instr, 32'h2222_2222);

    // async reset in the middle of HOLD
    cycle(1'b1, 1'b1, 1'b1, 32'h5555_5555, 1'b0, 32'h0);
    reset = 1'b0; m_rst_n = 1'b0; model_reset();
    #1;
    chk("lit_ar_fpc", F_PC, 32'h0000_3000);
    chk("lit_ar_dpc", D_PC, 32'h0);
    chk("lit_ar_dinstr", D_Instr, 32'h0);
    chk("lit_ar_req", {31'b0, imem_req}, 32'd0);
    chk("lit_ar_busy", {31'b0, F_busy}, 32'd0);
    chk("lit_ar_state", {31'b0, state_dbg}, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'h6666_6666, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("lit_ar_rel_req", {31'b0, o_req}, 32'd1);
    chk("lit_ar_rel_state", {31'b0, state_dbg}, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 32'h7777_7777, 1'b0, 32'h0);
    chk("lit_ar_dinstr2", D_Instr, 32'h7777_7777);
    chk("lit_ar_dpc2", D_PC, 32'h0000_3000);

    // wrap from 0xFFFF_FFFC to 0
    cycle(1'b1, 1'b0, 1'b1, 32'h8888_8888, 1'b1, 32'hFFFF_FFFC);
    chk("lit_wrap_hi", F_PC, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b1, 32'h9999_9999, 1'b0, 32'h0);
    chk("lit_wrap_fpc", F_PC, 32'h0000_0000);
    chk("lit_wrap_dpc", D_PC, 32'hFFFF_FFFC);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_st, r_rdy, r_redir;
      logic [31:0] r_tgt;
      r_rst   = ($urandom_range(199, 0) != 0);
      r_st    = ($urandom_range(99, 0) < 30);
      r_rdy   = ($urandom_range(99, 0) < 60);
      r_redir = ($urandom_range(99, 0) < 10);
      r_tgt   = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      cycle(r_rst, r_st, r_rdy, $urandom(), r_redir, r_tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- F-stage sequencer: the consumer of the next-PC value computed by the NPC block.
- Holds the architectural fetch PC and issues instruction-memory requests with a ready-based wait-state handshake.
- Loads the F/D pipeline register (D_PC, D_Instr) that the decode stage and the NPC branch/jump logic read.
- Buffers a returned instruction when the pipeline stalls, so no fetch is ever repeated or lost.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- NOP_INSTR, 32'h0000_0000, value placed in D_Instr at reset.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- NPC  input  32  next fetch address from the next-PC block (F_PC+4, branch, index or register target).
- stall  input  1  hazard-unit stall request for the F and D stages.
- F_PC  output  32  current fetch PC; also feeds the NPC block.
- imem_req  output  1  instruction-memory request valid.
- imem_addr  output  32  instruction-memory address; always equal to F_PC.
- imem_rdata  input  32  instruction word; valid only in a cycle where imem_ready=1.
- imem_ready  input  1  memory completes the pending request this cycle.
- F_busy  output  1  fetch wait; the hazard unit ORs it into the D stall and inserts an E bubble.
- D_PC  output  32  F/D register: PC of the instruction in D.
- D_Instr  output  32  F/D register: instruction in D.

Behaviour:
- Reset (reset=0, async):
  - F_PC=RESET_PC, D_PC=32'h0, D_Instr=NOP_INSTR.
  - hold_buf=0, state=FETCH.
  - imem_req and F_busy drop to 0 immediately, not at the next edge.
  - Reset mid-request aborts the request; any later imem_ready for it is ignored.
- States:
  - FETCH: request outstanding.
  - HOLD: an instruction is buffered while stall is asserted.
- Combinational outputs:
  - imem_req = reset & (state==FETCH).
  - imem_addr = F_PC.
  - F_busy = imem_req & ~imem_ready.
- FETCH, imem_ready=1, stall=0 (accept):
  - D_PC<=F_PC, D_Instr<=imem_rdata, F_PC<=NPC.
  - Stay in FETCH.
  - Zero-wait throughput is one instruction per cycle.
- FETCH, imem_ready=1, stall=1:
  - hold_buf<=imem_rdata; go to HOLD.
  - F_PC and D registers unchanged.
- FETCH, imem_ready=0:
  - F_PC and D registers hold, whatever stall is.
  - imem_addr stays stable until ready.
  - D must not be bubbled: the branch in D keeps driving the NPC target until its delay slot is accepted.
- HOLD, stall=1:
  - All registers hold; imem_req=0.
  - imem_ready is ignored.
- HOLD, stall=0:
  - D_PC<=F_PC, D_Instr<=hold_buf, F_PC<=NPC; go to FETCH.
  - The next request starts the following cycle.
- Latency:
  - Instruction fetched at address A appears on D_Instr/D_PC on the edge of its acceptance.
  - F_PC changes only on acceptance edges, so each address is requested exactly once.
- Control transfer:
  - F_PC takes whatever NPC presents on the acceptance edge.
  - On that edge, D holds the branch and F holds its delay slot.
  - The block performs no target arithmetic.
- Width rules:
  - F_PC is 32 bits and wraps modulo 2^32 (0xFFFF_FFFC + 4 -> 0 arrives via NPC).
  - No alignment check here; exception detection lives elsewhere.
- Simultaneous events:
  - Stall and ready in the same FETCH cycle: the stall wins for D, the data is captured in hold_buf.
  - Stall deasserting in the same cycle as ready: normal accept.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> F_PC=0x3000, D_Instr=0, imem_req=1 in the first cycle after release, F_busy=0 while in reset.
- Zero-wait stream: imem_ready=1 always, NPC=F_PC+4, words 0x1000_0001.. -> F_PC 0x3000,0x3004,0x3008 on successive edges; D_PC lags one cycle; D_Instr matches each word in order.
- Wait states: imem_ready=0 for 2 cycles at 0x3004 -> F_busy=1 for exactly 2 cycles; imem_addr stays 0x3004; D_PC stays 0x3000; then D_PC=0x3004 on the ready edge.
- Stall capture: ready=1 with stall=1 at 0x3008 (word 0xDEAD_BEEF), stall held 3 cycles -> imem_req=0 during HOLD; D_PC unchanged; on stall release D_Instr=0xDEAD_BEEF, D_PC=0x3008, F_PC=NPC; exactly one request to 0x3008.
- Branch redirect: NPC=0x3100 on the delay-slot accept edge with 1 wait state -> D holds the branch through the wait; next F_PC=0x3100; D_PC=delay-slot PC.
- Async reset mid-HOLD: drop reset between edges -> outputs return to reset values before the next clk edge; state=FETCH after release.
